// File: rtl/frame_seq.sv
// Call/return context sequencer: spills the register file to a DMEM stack frame on CALL and
// refills it on RET. Optional FRAME_SEQ_CLEAR_EN zeroes r1.. of the register file while saving.
module frame_seq #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NSAVE      = 16,
    parameter int unsigned MAX_DEPTH  = 8,
    parameter logic [31:0] STACK_BASE = 32'h0000_F000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      state_mode_next,
    output logic [1:0]      state_mode,
    output logic [7:0]      sc,
    output logic            busy,
    output logic            done,
    output logic [3:0]      depth,
    output logic            ovf,
    output logic            unf,
    output logic [5:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic [5:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_we,
    output logic [31:0]     dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    input  logic [XLEN-1:0] dmem_rdata
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSave    = 2'd1;
    localparam logic [1:0] StRestore = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [1:0] ModeImem = 2'd0;
    localparam logic [1:0] ModeCall = 2'd1;
    localparam logic [1:0] ModeRet  = 2'd2;

    localparam logic [7:0]  ScLast     = 8'(NSAVE - 1);
    localparam logic [7:0]  ScEnd      = 8'(NSAVE);
    localparam logic [3:0]  DepthMax   = 4'(MAX_DEPTH);
    localparam logic [31:0] FrameBytes = 32'(NSAVE * 4);

    logic [1:0]  state_q, state_d;
    logic [7:0]  sc_q, sc_d;
    logic [3:0]  depth_q, depth_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic [31:0] frame_base;
    logic [31:0] word_addr;

    // RESTORE sees the already-decremented depth, so both directions address the same frame.
    assign frame_base = STACK_BASE + 32'(depth_q) * FrameBytes;
    assign word_addr  = frame_base + {22'd0, sc_q, 2'b00};

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            StIdle: begin
                sc_d = 8'd0;
                if (state_mode_next == ModeCall) begin
                    if (depth_q < DepthMax) begin
                        state_d = StSave;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (state_mode_next == ModeRet) begin
                    if (depth_q != 4'd0) begin
                        depth_d = depth_q - 4'd1;
                        state_d = StRestore;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
            end
            StSave: begin
                if (sc_q == ScLast) begin
                    sc_d    = 8'd0;
                    depth_d = depth_q + 4'd1;
                    state_d = StDone;
                end else begin
                    sc_d = sc_q + 8'd1;
                end
            end
            StRestore: begin
                // One extra cycle after the last read drains the final writeback.
                if (sc_q == ScEnd) begin
                    sc_d    = 8'd0;
                    state_d = StDone;
                end else begin
                    sc_d = sc_q + 8'd1;
                end
            end
            StDone: begin
                sc_d    = 8'd0;
                state_d = StIdle;
            end
            default: begin
                sc_d    = 8'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sc_q    <= 8'd0;
            depth_q <= 4'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_mode = ModeImem;
        busy       = 1'b0;
        done       = 1'b0;
        rf_raddr   = 6'd0;
        rf_waddr   = 6'd0;
        rf_wdata   = '0;
        rf_we      = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;
        case (state_q)
            StSave: begin
                busy       = 1'b1;
                state_mode = ModeCall;
                rf_raddr   = sc_q[5:0];
                dmem_addr  = word_addr;
                dmem_wdata = rf_rdata;
                dmem_we    = 1'b1;
`ifdef FRAME_SEQ_CLEAR_EN
                // Read-before-write on the same address: the old value reaches DMEM this cycle.
                rf_waddr   = sc_q[5:0];
                rf_wdata   = '0;
                rf_we      = (sc_q != 8'd0);
`endif
            end
            StRestore: begin
                busy       = 1'b1;
                state_mode = ModeRet;
                if (sc_q != ScEnd) begin
                    dmem_addr = word_addr;
                end
                if (sc_q != 8'd0) begin
                    rf_we    = 1'b1;
                    rf_waddr = 6'(sc_q - 8'd1);
                    rf_wdata = dmem_rdata;
                end
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign sc    = sc_q;
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_frame_seq.sv
// Randomised bench for frame_seq: a frame-stack model predicts DMEM traffic, register file
// contents, latency and flags for every request.
module tb_frame_seq;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NSAVE      = 16;
    localparam int unsigned MAX_DEPTH  = 8;
    localparam logic [31:0] STACK_BASE = 32'h0000_F000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      state_mode_next = 2'd0;
    logic [1:0]      state_mode;
    logic [7:0]      sc;
    logic            busy, done, ovf, unf;
    logic [3:0]      depth;
    logic [5:0]      rf_raddr, rf_waddr;
    logic [XLEN-1:0] rf_rdata, rf_wdata;
    logic            rf_we;
    logic [31:0]     dmem_addr;
    logic [XLEN-1:0] dmem_wdata, dmem_rdata;
    logic            dmem_we;

    frame_seq #(
        .XLEN      (XLEN),
        .NSAVE     (NSAVE),
        .MAX_DEPTH (MAX_DEPTH),
        .STACK_BASE(STACK_BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .state_mode_next(state_mode_next),
        .state_mode     (state_mode),
        .sc             (sc),
        .busy           (busy),
        .done           (done),
        .depth          (depth),
        .ovf            (ovf),
        .unf            (unf),
        .rf_raddr       (rf_raddr),
        .rf_rdata       (rf_rdata),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_we          (rf_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_we        (dmem_we),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Environment: register file (async read), DMEM (sync read) and write logs.
    logic [31:0] rf [64];
    logic [31:0] mem [1024];
    logic [31:0] load_val [64];
    logic        load_req = 1'b0;
    logic [31:0] dlog_addr[$], dlog_data[$], rlog_addr[$], rlog_data[$];

    assign rf_rdata = rf[rf_raddr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) rf[i] <= load_val[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            rlog_addr.push_back(32'(rf_waddr));
            rlog_data.push_back(rf_wdata);
        end
        if (dmem_we) begin
            mem[dmem_addr[11:2]] <= dmem_wdata;
            dlog_addr.push_back(dmem_addr);
            dlog_data.push_back(dmem_wdata);
        end
        dmem_rdata <= mem[dmem_addr[11:2]];
    end

    // Reference model: register values, a stack of saved frames, depth and sticky flags.
    logic [31:0] m_regs [64];
    logic [31:0] m_frames [MAX_DEPTH][NSAVE];
    int          m_depth;
    bit          m_ovf, m_unf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_regs();
        @(negedge clk);
        for (int i = 0; i < 64; i++) load_val[i] = m_regs[i];
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mode", 32'(state_mode), 32'd0);
        check("rst_sc", 32'(sc), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {28'd0, done, ovf, unf, rf_we}, 32'd0);
        check("rst_dmem", {31'd0, dmem_we} | dmem_addr, 32'd0);
        rst = 1'b0;
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Present an accepted request and follow it to the done pulse.
    task automatic issue(input logic [1:0] req, output int lat, output int max_sc);
        @(negedge clk);
        state_mode_next = req;
        @(posedge clk);
        #1 state_mode_next = 2'd0;
        lat    = 1;
        max_sc = 0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_mode", 32'(state_mode), 32'(req));
        while (!done && lat < 200) begin
            if (int'(sc) > max_sc) max_sc = int'(sc);
            @(posedge clk);
            #1 lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_idle", {29'd0, busy, state_mode}, 32'd0);
        check("done_sc", 32'(sc), 32'd0);
        @(posedge clk);
        #1 check("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic do_req(input logic [1:0] req);
        int          lat, max_sc, db, rb, nbad;
        logic [31:0] fb;
        db = dlog_addr.size();
        rb = rlog_addr.size();
        if (req == 2'd1 && m_depth < int'(MAX_DEPTH)) begin
            fb = STACK_BASE + 32'(m_depth) * 32'(NSAVE * 4);
            for (int i = 0; i < int'(NSAVE); i++) m_frames[m_depth][i] = m_regs[i];
            issue(req, lat, max_sc);
            check("call_lat", 32'(lat), 32'(NSAVE + 1));
            check("call_maxsc", 32'(max_sc), 32'(NSAVE - 1));
            check("call_nwr", 32'(dlog_addr.size() - db), 32'(NSAVE));
            for (int i = 0; i < int'(NSAVE) && db + i < dlog_addr.size(); i++) begin
                check("call_addr", dlog_addr[db + i], fb + 32'(i * 4));
                check("call_data", dlog_data[db + i], m_frames[m_depth][i]);
            end
`ifdef FRAME_SEQ_CLEAR_EN
            check("call_nclr", 32'(rlog_addr.size() - rb), 32'(NSAVE - 1));
            for (int i = 1; i < int'(NSAVE); i++) m_regs[i] = 32'd0;
`else
            check("call_nrf", 32'(rlog_addr.size() - rb), 32'd0);
`endif
            m_depth++;
        end else if (req == 2'd2 && m_depth > 0) begin
            m_depth--;
            issue(req, lat, max_sc);
            check("ret_lat", 32'(lat), 32'(NSAVE + 2));
            check("ret_maxsc", 32'(max_sc), 32'(NSAVE));
            check("ret_ndmem", 32'(dlog_addr.size() - db), 32'd0);
            check("ret_nrf", 32'(rlog_addr.size() - rb), 32'(NSAVE));
            for (int i = 0; i < int'(NSAVE) && rb + i < rlog_addr.size(); i++) begin
                check("ret_waddr", rlog_addr[rb + i], 32'(i));
                check("ret_wdata", rlog_data[rb + i], m_frames[m_depth][i]);
            end
            for (int i = 0; i < int'(NSAVE); i++) m_regs[i] = m_frames[m_depth][i];
        end else begin
            if (req == 2'd1) m_ovf = 1'b1;
            if (req == 2'd2) m_unf = 1'b1;
            @(negedge clk);
            state_mode_next = req;
            @(posedge clk);
            #1 state_mode_next = 2'd0;
            check("rej_busy", 32'(busy), 32'd0);
            check("rej_mode", 32'(state_mode), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            check("rej_busy2", 32'(busy), 32'd0);
            check("rej_nwr", 32'((dlog_addr.size() - db) + (rlog_addr.size() - rb)), 32'd0);
        end
        check("depth", 32'(depth), 32'(m_depth));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("unf", 32'(unf), 32'(m_unf));
        nbad = 0;
        for (int i = 0; i < 64; i++) if (rf[i] !== m_regs[i]) nbad++;
        check("regfile", 32'(nbad), 32'd0);
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 64; i++) m_regs[i] = $urandom;
        load_regs();
    endtask

    initial begin
        int lat;
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        reset_dut();

        // Known pattern r_i = 0x100+i, save it, clobber, restore.
        for (int i = 0; i < 64; i++) m_regs[i] = (i < 16) ? 32'h100 + 32'(i) : $urandom;
        load_regs();
        do_req(2'd1);
        for (int i = 0; i < 16; i++) m_regs[i] = 32'hDEAD;
        load_regs();
        do_req(2'd2);
        check("restored_r5", rf[5], 32'h105);

        do_req(2'd2);  // underflow
        do_req(2'd0);
        do_req(2'd3);

        // Fill the stack, then overflow; frame 7 lands at 0xF1C0.
        for (int n = 0; n < int'(MAX_DEPTH); n++) begin
            randomize_regs();
            do_req(2'd1);
        end
        check("frame7_base", dlog_addr[dlog_addr.size() - NSAVE], 32'h0000_F1C0);
        do_req(2'd1);
        do_req(2'd2);
        do_req(2'd2);

        // Reset in the middle of a save.
        @(negedge clk);
        state_mode_next = 2'd1;
        @(posedge clk);
        #1 state_mode_next = 2'd0;
        lat = 0;
        while (sc != 8'd5 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check("mid_sc5", 32'(sc), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_sc", 32'(sc), 32'd0);
        check("mid_depth", 32'(depth), 32'd0);
        check("mid_dmem_we", 32'(dmem_we), 32'd0);
        check("mid_ovf", 32'(ovf), 32'd0);
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        randomize_regs();

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) randomize_regs();
            do_req(2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
